perspective_correct: RTL
========================

PERSPECTIVE_CORRECT -- requirements
Module: perspective_correct

Interface
REQ-001 SHALL have parameter DIV_BITS, default 33, number of quotient bits produced by the reciprocal divider, one bit per cycle.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port frag_in  input  fragment_t  rasterizer fragment; u,v,r,g,b carry attr*w.
REQ-005 SHALL have port w_in  input  fp32_t  interpolated w (Q16.16 signed) for frag_in.
REQ-006 SHALL have port in_valid  input  1  frag_in/w_in valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a fragment.
REQ-008 SHALL have port frag_out  output  fragment_t  perspective-corrected fragment.
REQ-009 SHALL have port out_valid  output  1  frag_out valid.
REQ-010 SHALL have port out_ready  input  1  downstream backpressure.
REQ-011 SHALL have port drop  output  1  one-cycle pulse when a fragment is discarded for w <= 0.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL use states IDLE, DIVIDE, MULTIPLY, OUTPUT; in_ready = (state == IDLE).
REQ-014 IDLE: on in_valid && in_ready, SHALL latch frag_in and w_in; w_in <= 0 -> stay IDLE, pulse drop next cycle, no output; else -> DIVIDE.
REQ-015 DIVIDE SHALL compute recip = floor(2^32 / w) unsigned, radix-2 restoring, exactly DIV_BITS cycles, then -> MULTIPLY.
REQ-016 If the quotient is >= 2^31, recip SHALL saturate to 0x7FFF_FFFF (PC_RECIP_MAX).
REQ-017 MULTIPLY (1 cycle) SHALL compute u,v,r,g,b = fp_mul(attr_w, recip) (signed product, arithmetic shift right 16, truncate), then -> OUTPUT.
REQ-018 r,g,b SHALL clamp to [0x0000_0000, FP_ONE = 0x0001_0000]; u,v SHALL NOT clamp.
REQ-019 x, y, z SHALL pass through unchanged from the latched fragment.
REQ-020 OUTPUT: out_valid = 1, frag_out.valid = 1; frag_out SHALL stay stable until out_ready; on out_valid && out_ready -> IDLE.
REQ-021 Latency SHALL be fixed: acceptance at edge T, out_valid first high in the cycle after edge T+DIV_BITS+2 (T+35 at default); throughput is one fragment per DIV_BITS+3 cycles minimum.
REQ-022 out_valid and frag_out.valid SHALL be 0 in every state except OUTPUT; frag_out fields SHALL hold their last values outside OUTPUT.
REQ-023 in_valid while not in IDLE SHALL be ignored; the upstream stalls on in_ready = 0.
REQ-024 drop SHALL never be asserted in the same cycle as out_valid.

Reset
REQ-025 rst SHALL force state IDLE, out_valid 0, drop 0, busy 0, in_ready 1 on the next edge, and zero frag_out and all datapath registers.
REQ-026 rst asserted mid-DIVIDE, MULTIPLY or OUTPUT SHALL discard the in-flight fragment with no out_valid and no drop.

Structure
REQ-027 fragment_t, fp32_t, FP_ONE and fp_mul SHALL come from celery_pkg; PC_RECIP_MAX SHALL be added to celery_pkg.
REQ-028 The state enum SHALL be local to the module.
REQ-029 The iterative divider SHALL be one sub-module, recip_div (start/done handshake, DIV_BITS cycles, saturation inside), with clk and rst as in REQ-002/003.

Verification
REQ-030 w=0x0001_0000, u=0x0002_0000, r=0x0000_8000 -> out_valid at T+35, u=0x0002_0000, r=0x0000_8000, x/y/z unchanged.
REQ-031 w=0x0002_0000, uw=0x0001_0000, gw=0x0001_0000 -> recip=0x0000_8000, u=0x0000_8000, g=0x0000_8000.
REQ-032 w=0x0001_0000, rw=0x0003_0000, bw=0xFFFF_0000 -> r=0x0001_0000, b=0x0000_0000 (clamped).
REQ-033 w=0x0000_0000 and then w=0xFFFF_0000 -> drop pulses once per fragment, out_valid never high, in_ready back to 1 within 1 cycle.
REQ-034 w=0x0000_0001 -> recip saturates to 0x7FFF_FFFF; out_ready held 0 for 10 cycles -> frag_out stable, in_ready 0 throughout.
REQ-035 rst asserted at T+10 of a DIVIDE -> next cycle state IDLE, in_ready 1, out_valid 0, no drop pulse; a fresh fragment completes normally.

Source files
------------

// File: rtl/celery_pkg.sv
// Shared fixed-point types and helpers for the fragment pipeline.
// Values are Q16.16 signed; attributes arrive pre-multiplied by w.
package celery_pkg;

   typedef logic signed [31:0] fp32_t;

   typedef struct packed {
      logic        valid;
      logic [15:0] x;
      logic [15:0] y;
      fp32_t       z;
      fp32_t       u;
      fp32_t       v;
      fp32_t       r;
      fp32_t       g;
      fp32_t       b;
   } fragment_t;

   localparam fp32_t       FP_ONE       = 32'sh0001_0000;
   // Largest reciprocal that still reads as a positive Q16.16 value.
   localparam logic [31:0] PC_RECIP_MAX = 32'h7FFF_FFFF;

   // Q16.16 multiply: full signed product, arithmetic shift by 16, keep low 32 bits.
   function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
      logic signed [63:0] prod;
      prod = 64'(a) * 64'(b);
      return fp32_t'(prod >>> 16);
   endfunction

   // Clamp a colour channel into [0, 1.0].
   function automatic fp32_t fp_clamp_unit(input fp32_t x);
      fp32_t res;
      if (x < 32'sd0) begin
         res = 32'sd0;
      end else if (x > FP_ONE) begin
         res = FP_ONE;
      end else begin
         res = x;
      end
      return res;
   endfunction

endpackage

// File: rtl/perspective_correct_if.sv
// Fragment stream into and out of the perspective-correction stage.
// slave = the correction block, master = the rasterizer/consumer side.
interface perspective_correct_if;
   import celery_pkg::*;

   fragment_t frag_in;
   fp32_t     w_in;
   logic      in_valid;
   logic      in_ready;
   fragment_t frag_out;
   logic      out_valid;
   logic      out_ready;
   logic      drop;
   logic      busy;

   modport slave (
      input  frag_in, w_in, in_valid, out_ready,
      output in_ready, frag_out, out_valid, drop, busy
   );

   modport master (
      output frag_in, w_in, in_valid, out_ready,
      input  in_ready, frag_out, out_valid, drop, busy
   );

endinterface

// File: rtl/perspective_correct_recip_div.sv
// Iterative radix-2 restoring divider producing floor(2^(DIV_BITS-1) / divisor),
// i.e. floor(2^32 / w) at the default width, one quotient bit per cycle.
// Results at or above 2^31 saturate so they stay positive in Q16.16.
module recip_div
#(
   parameter int unsigned DIV_BITS = 33
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] recip
);
   import celery_pkg::*;

   localparam int unsigned CNT_W = $clog2(DIV_BITS + 1);

   logic [31:0]         rem_r;
   logic [DIV_BITS-1:0] dvd_r;
   logic [DIV_BITS-2:0] quo_r;
   logic [31:0]         dsr_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                run_r;
   logic                done_r;
   logic [31:0]         recip_r;

   logic [32:0]         rem_sh_s;
   logic                ge_s;
   logic [DIV_BITS-1:0] q_next_s;
   logic                sat_s;

   // One restoring step: shift in the next dividend bit and trial-subtract.
   always_comb begin
      rem_sh_s = {rem_r, dvd_r[DIV_BITS-1]};
      ge_s     = (rem_sh_s >= {1'b0, dsr_r});
      q_next_s = {quo_r, ge_s};
      sat_s    = (64'(q_next_s) >= 64'h0000_0000_8000_0000);
   end

   // Iteration control: load on start, run DIV_BITS steps, pulse done with the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r   <= 32'h0000_0000;
         dvd_r   <= '0;
         quo_r   <= '0;
         dsr_r   <= 32'h0000_0000;
         cnt_r   <= '0;
         run_r   <= 1'b0;
         done_r  <= 1'b0;
         recip_r <= 32'h0000_0000;
      end else begin
         done_r <= 1'b0;
         if (run_r) begin
            rem_r <= 32'(ge_s ? rem_sh_s - {1'b0, dsr_r} : rem_sh_s);
            dvd_r <= dvd_r << 1;
            quo_r <= q_next_s[DIV_BITS-2:0];
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
               run_r   <= 1'b0;
               done_r  <= 1'b1;
               recip_r <= sat_s ? PC_RECIP_MAX : 32'(q_next_s);
            end
         end else if (start) begin
            rem_r <= 32'h0000_0000;
            dvd_r <= {1'b1, {(DIV_BITS-1){1'b0}}};
            quo_r <= '0;
            dsr_r <= divisor;
            cnt_r <= CNT_W'(DIV_BITS);
            run_r <= 1'b1;
         end
      end
   end

   assign done  = done_r;
   assign recip = recip_r;

endmodule

// File: rtl/perspective_correct.sv
// Perspective correction: divides each w-premultiplied attribute by w via a
// reciprocal, clamps colour channels, and hands the fragment downstream.
// Fragments with w <= 0 are discarded with a one-cycle drop pulse.
module perspective_correct
#(
   parameter int unsigned DIV_BITS = 33
)
(
   input  logic                 clk,
   input  logic                 rst,
   perspective_correct_if.slave pc
);
   import celery_pkg::*;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DIVIDE   = 2'd1,
      ST_MULTIPLY = 2'd2,
      ST_OUTPUT   = 2'd3
   } state_t;

   state_t      state_r;
   fragment_t   frag_r;
   logic [31:0] recip_r;
   fragment_t   frag_out_r;
   logic        out_valid_r;
   logic        in_ready_r;
   logic        busy_r;
   logic        drop_r;

   logic        accept_s;
   logic        w_pos_s;
   logic        div_start_s;
   logic        div_done_s;
   logic [31:0] div_recip_s;
   fragment_t   corrected_s;

   // Handshake decode: a positive w starts the divider on acceptance.
   always_comb begin
      accept_s    = pc.in_valid && in_ready_r;
      w_pos_s     = !pc.w_in[31] && (pc.w_in != 32'sd0);
      div_start_s = accept_s && w_pos_s;
   end

   recip_div #(.DIV_BITS(DIV_BITS)) u_recip_div (
      .clk     (clk),
      .rst     (rst),
      .start   (div_start_s),
      .divisor (pc.w_in),
      .done    (div_done_s),
      .recip   (div_recip_s)
   );

   // Attribute correction: scale by 1/w; only colour channels are clamped.
   always_comb begin
      corrected_s   = frag_r;
      corrected_s.u = fp_mul(frag_r.u, recip_r);
      corrected_s.v = fp_mul(frag_r.v, recip_r);
      corrected_s.r = fp_clamp_unit(fp_mul(frag_r.r, recip_r));
      corrected_s.g = fp_clamp_unit(fp_mul(frag_r.g, recip_r));
      corrected_s.b = fp_clamp_unit(fp_mul(frag_r.b, recip_r));
   end

   // Control FSM with registered handshake, status and output fragment.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         frag_r      <= '0;
         recip_r     <= 32'h0000_0000;
         frag_out_r  <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         drop_r      <= 1'b0;
      end else begin
         drop_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  frag_r       <= pc.frag_in;
                  // valid marks the latched slot as holding a live fragment
                  frag_r.valid <= 1'b1;
                  if (w_pos_s) begin
                     state_r    <= ST_DIVIDE;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b1;
                  end else begin
                     drop_r <= 1'b1;
                  end
               end
            end
            ST_DIVIDE: begin
               if (div_done_s) begin
                  recip_r <= div_recip_s;
                  state_r <= ST_MULTIPLY;
               end
            end
            ST_MULTIPLY: begin
               frag_out_r  <= corrected_s;
               out_valid_r <= 1'b1;
               state_r     <= ST_OUTPUT;
            end
            ST_OUTPUT: begin
               if (pc.out_ready) begin
                  out_valid_r      <= 1'b0;
                  frag_out_r.valid <= 1'b0;
                  state_r          <= ST_IDLE;
                  in_ready_r       <= 1'b1;
                  busy_r           <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign pc.in_ready  = in_ready_r;
   assign pc.frag_out  = frag_out_r;
   assign pc.out_valid = out_valid_r;
   assign pc.drop      = drop_r;
   assign pc.busy      = busy_r;

endmodule
